// File: rtl/bls_div_pkg.sv
// Shared types and sizing helpers for the time-shared BLS restoring divider.
package bls_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DIVISOR_W      = 4;
    localparam int DIVIDEND_W_DEF = 8;

    // Iteration counter width: ceil(log2(w)), never below one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/Lab2_4_bit_BLS_behavioral.sv
// 4-bit borrow-lookahead subtractor: d = a - b - bin, bout is the borrow out of bit 3.
module Lab2_4_bit_BLS_behavioral (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [3:0] g, p;
    logic [4:0] c;

    // A bit generates a borrow when a=0,b=1 and propagates one when a==b.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign c[0] = bin;
    assign c[1] = g[0] | (p[0] & bin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ c[3:0];
    assign bout = c[4];
endmodule

// File: rtl/bls_restoring_divider.sv
// Restoring divider: one quotient bit per clock through a single shared 4-bit BLS subtractor.
module bls_restoring_divider
    import bls_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int CW = cnt_width(DIVIDEND_W);

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, quo_q;
    logic [DIVISOR_W-1:0]  dvs_q, rem_q;
    logic [CW-1:0]         cnt_q;
    logic                  dbz_q;

    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff, rem_nxt;
    logic                  bout, accept, last, take;

    assign trial = {rem_q, dvd_q[DIVIDEND_W-1]};

    Lab2_4_bit_BLS_behavioral u_bls (
        .a    (trial[3:0]),
        .b    (dvs_q),
        .bin  (1'b0),
        .d    (diff),
        .bout (bout)
    );

    // With trial[4] set the trial is at least 16, so the 4-bit difference is exact.
    assign accept  = trial[4] | ~bout;
    assign rem_nxt = accept ? diff : trial[3:0];
    assign last    = (cnt_q == CW'(DIVIDEND_W - 1));
    assign take    = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = (divisor == '0) ? DONE : RUN;
                else
                    state_d = IDLE;
            end
            RUN:     if (last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else if (take) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
            if (divisor == '0) begin
                quo_q <= '1;
                rem_q <= 4'(dividend);
                dbz_q <= 1'b1;
            end else begin
                quo_q <= '0;
                rem_q <= '0;
                dbz_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            rem_q <= rem_nxt;
            quo_q <= (quo_q << 1) | DIVIDEND_W'(accept);
            dvd_q <= dvd_q << 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/bls_restoring_divider.md
# bls_restoring_divider

Sequential restoring divider that time-shares one 4-bit borrow-lookahead subtractor to divide a DIVIDEND_W-bit unsigned dividend by a 4-bit unsigned divisor. It produces one quotient bit per clock. It is the controller layer above the 4-bit BLS datapath: it sequences the operands into the subtractor, decides restore or accept from its borrow-out, and exposes a start/busy/done handshake to the surrounding lab system.

## Interface
- DIVIDEND_W, default 8: dividend and quotient width; legal range 1–16.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  DIVIDEND_W  unsigned dividend, captured on the accepted start.
- divisor  in  4  unsigned divisor, captured on the accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  DIVIDEND_W  quotient, held until the next accepted start.
- remainder  out  4  remainder, held until the next accepted start.
- div_by_zero  out  1  set with done when the captured divisor is 0; held like the results.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start with divisor≠0.
  - IDLE→DONE on start with divisor=0.
  - RUN→DONE when the iteration counter reaches DIVIDEND_W−1.
  - DONE→RUN or DONE→DONE on start, using the same divisor test as IDLE.
  - DONE→IDLE otherwise.
- Registers:
  - dvd_q: dividend shift register, DIVIDEND_W bits.
  - dvs_q: divisor, 4 bits.
  - rem_q: partial remainder, 4 bits.
  - quo_q: quotient, DIVIDEND_W bits.
  - cnt_q: iteration counter, ceil(log2(DIVIDEND_W)) bits, minimum 1.
- Accepted start: dvd_q←dividend, dvs_q←divisor, rem_q←0, quo_q←0, cnt_q←0, div_by_zero←0.
- Each RUN cycle:
  - Form the 5-bit trial {rem_q, dvd_q[MSB]}.
  - Subtractor inputs: A = trial[3:0], B = dvs_q, bin tied to 0.
  - Subtraction is accepted when trial[4]=1 or bout=0.
  - On accept: rem_q←D, quotient bit = 1.
  - On reject: rem_q←trial[3:0], quotient bit = 0.
  - Shift the quotient bit into the LSB of quo_q; shift dvd_q left by 1; cnt_q increments.
  - Width rule: when trial[4]=1, trial ≥ 16 > dvs_q, so the 4-bit difference D is exact. Ignore bout in that case.
- Divide by zero: no RUN cycles. Set quotient = all ones, remainder = dividend[3:0] (upper bits dropped), div_by_zero = 1.
- start is ignored while in RUN. Captured operands are immune to input changes after capture.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, all internal registers 0.
- Reset in any state, including mid-RUN, aborts the operation. The block is in IDLE with all outputs 0 on the cycle after the rst edge. No done is produced for the aborted operation.
- Start sampled at edge k: busy=1 from k+1 through k+DIVIDEND_W. done=1 at k+DIVIDEND_W+1 only.
- Divide by zero: done=1 at k+1. busy stays 0.
- quotient and remainder drive directly from quo_q and rem_q. They are meaningful when done=1 and stay stable until the next accepted start.
- Back-to-back operation: start during the DONE cycle gives busy at the next cycle. Throughput is one result per DIVIDEND_W+1 cycles.
- The subtractor is purely combinational and lies inside a single cycle: rem_q → BLS → rem_q.

## Structure
- Shared package `bls_div_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - DIVISOR_W = 4.
  - DIVIDEND_W default.
  - counter-width function.
- One sub-module: the existing 4-bit borrow-lookahead subtractor `Lab2_4_bit_BLS_behavioral`, instantiated once, unmodified, with bin tied to 0.
- The controller holds only the FSM, the registers and the accept mux.

## Test plan
- dividend=100, divisor=7, start at edge 0 → busy during cycles 1–8, done at cycle 9, quotient=14, remainder=2, div_by_zero=0.
- 255/1 → quotient=255, remainder=0. Then 255/15 → quotient=17, remainder=0. Then 13/15 → quotient=0, remainder=13. All at DIVIDEND_W=8.
- dividend=200, divisor=0 → done at cycle 1, busy never high, quotient=0xFF, remainder=8, div_by_zero=1.
- Operations issued after a reset:
  - Start 100/7, pulse rst at cycle 4 → IDLE next cycle, all outputs 0, no done.
  - Start 9/3 → quotient=3, remainder=0.
- Handshake:
  - Toggle start and operands during RUN of 50/6 → ignored; result is quotient=8, remainder=2.
  - Start 77/5 in the DONE cycle → busy next cycle, then quotient=15, remainder=2.
- Exhaustive self-check over all 256×16 operand pairs at DIVIDEND_W=8, plus random runs at DIVIDEND_W=4 and 16. Compare against / and % (and the divide-by-zero rule). Assert done is exactly one cycle wide.
